text_screen_buffer: RTL and testbench
=====================================

# text_screen_buffer

Character storage stage directly downstream of the character feeder: holds the 15×40 glyph-index screen and applies the feeder's per-character writes, scroll-up (`push_up`) and clear (`reset_call`) commands. A 4-entry command FIFO absorbs requests while multi-cycle scroll and clear sequences run, since the feeder has no backpressure. An independent synchronous read port serves the display renderer.

## Interface
- `ROW_NUMBER`, 15: screen lines
- `COL_NUMBER`, 40: characters per line
- `ROW_BIT_LEN`, 4: row index width
- `COL_BIT_LEN`, 6: column index width
- `CHAR_ID_LEN`, 8: glyph index width
- `BLANK_ID`, 128: glyph written by clear and scroll-fill
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2)

Ports:
- `clock`  in  1  sole clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high
- `wr_valid`  in  1  feeder write strobe; samples the other feeder signals
- `char_id`  in  CHAR_ID_LEN  glyph index from feeder
- `wr_row`  in  ROW_BIT_LEN  target row
- `wr_col`  in  COL_BIT_LEN  target column
- `push_up`  in  1  scroll screen up one line before this write
- `reset_call`  in  1  clear entire screen
- `rd_row`  in  ROW_BIT_LEN  renderer read row
- `rd_col`  in  COL_BIT_LEN  renderer read column
- `rd_char`  out  CHAR_ID_LEN  glyph at (rd_row, rd_col), one cycle later
- `busy`  out  1  scroll or clear sequence in progress
- `overflow`  out  1  sticky: a command was dropped on FIFO full

## Operation
- Storage: ROW_NUMBER×COL_NUMBER entries, address = row×COL_NUMBER+col; one write port, one engine read port, one renderer read port.
- Enqueue, each posedge with `wr_valid`=1:
  - `reset_call`=1 → CLEAR entry; `char_id` ignored, other bits ignored.
  - else `push_up`=1 → SCROLL_WRITE entry; its row is forced to ROW_NUMBER-1.
  - else → WRITE entry, provided `wr_row`<ROW_NUMBER and `wr_col`<COL_NUMBER; otherwise dropped silently.
  - `char_id`==8'hFF is never stored (a WRITE carrying it is dropped).
- Inputs are ignored when `wr_valid`=0.
- FIFO full on enqueue → entry dropped, `overflow`←1. `overflow` is cleared only by `reset` or by execution of a CLEAR.
- FSM states:
  - IDLE: if FIFO non-empty, pop. WRITE: store at the next edge, remain IDLE (no `busy`). SCROLL_WRITE → SCROLL_COPY. CLEAR → CLEAR.
  - SCROLL_COPY: one prefetch cycle, then 560 pipelined cycles; each reads cell i+COL_NUMBER and writes cell i, for i=0..(ROW_NUMBER-1)×COL_NUMBER-1 → SCROLL_FILL.
  - SCROLL_FILL: writes BLANK_ID to row ROW_NUMBER-1, cols 0..39 (40 cycles), then the popped char at (ROW_NUMBER-1, wr_col) → IDLE.
  - CLEAR: writes BLANK_ID to addresses 0..599 (600 cycles), clears `overflow` → IDLE.
- Enqueue continues in every state; order of execution is FIFO order.
- Renderer port is never stalled and may observe partially scrolled or cleared contents.
- Out-of-range read address → `rd_char`=BLANK_ID.

## Timing
- `reset` values: `rd_char`=BLANK_ID, `busy`=0, `overflow`=0, FIFO empty, FSM IDLE. Storage contents are undefined.
- Read latency: 1 cycle.
- WRITE enqueued at edge N is popped at N+1, stored at N+2, and visible on `rd_char` at N+3 when addressed at N+2.
- `busy` rises the edge after a SCROLL_WRITE or CLEAR is popped and falls on the edge the FSM returns to IDLE.
  - Scroll: `busy` high 602 cycles (1 prefetch + 560 + 40 + 1).
  - Clear: `busy` high 600 cycles.
- Simultaneous enqueue and pop with a full FIFO: the pop frees a slot first, and the entry is accepted.
- `reset` asserted mid-sequence aborts immediately; partially updated storage remains.

## Configuration
- `TEXT_BUFFER_CLEAR_ON_RESET_EN`
  - Defined: on `reset` release the FSM enters CLEAR directly with `busy`=1 (reset value of `busy` is 1). Contents are all BLANK_ID 600 cycles later.
  - Undefined: FSM starts in IDLE, and contents stay undefined until the first CLEAR.

## Test plan
- WRITE (row 2, col 5, char 36), then read (2,5) two cycles later → `rd_char`=36, `busy` never asserted.
- CLEAR, then after 600 busy cycles read (0,0), (14,39) → both 128, `overflow`=0.
- Fill rows 0–14 with col-index chars, SCROLL_WRITE char 7 → after 602 cycles, row 0 holds the former row 1, row 14 holds col 0=7 and cols 1–39=128.
- During a scroll, issue 5 WRITEs → first 4 execute in order after scroll; 5th dropped, `overflow`=1 until next CLEAR.
- WRITE with `wr_row`=15 without `push_up`, and WRITE with `char_id`=8'hFF → storage unchanged.
- With `TEXT_BUFFER_CLEAR_ON_RESET_EN`: release `reset` → `busy`=1 for 600 cycles, then every read returns 128.

Source files
------------

// File: rtl/text_screen_buffer_if.sv
// Feeder / renderer bus of the text screen buffer.
// master: feeder + renderer side, slave: the buffer itself.
interface text_screen_buffer_if #(
   parameter int ROW_BIT_LEN = 4,
   parameter int COL_BIT_LEN = 6,
   parameter int CHAR_ID_LEN = 8
);
   logic                   wr_valid;
   logic [CHAR_ID_LEN-1:0] char_id;
   logic [ROW_BIT_LEN-1:0] wr_row;
   logic [COL_BIT_LEN-1:0] wr_col;
   logic                   push_up;
   logic                   reset_call;
   logic [ROW_BIT_LEN-1:0] rd_row;
   logic [COL_BIT_LEN-1:0] rd_col;
   logic [CHAR_ID_LEN-1:0] rd_char;
   logic                   busy;
   logic                   overflow;

   modport master (
      output wr_valid, char_id, wr_row, wr_col, push_up, reset_call, rd_row, rd_col,
      input  rd_char, busy, overflow
   );

   modport slave (
      input  wr_valid, char_id, wr_row, wr_col, push_up, reset_call, rd_row, rd_col,
      output rd_char, busy, overflow
   );
endinterface

// File: rtl/text_screen_buffer.sv
// 15x40 glyph screen store with command FIFO, scroll/clear engine and renderer read port.
// Optional TEXT_BUFFER_CLEAR_ON_RESET_EN: run a full clear straight out of reset.
module text_screen_buffer #(
   parameter int ROW_NUMBER  = 15,
   parameter int COL_NUMBER  = 40,
   parameter int ROW_BIT_LEN = 4,
   parameter int COL_BIT_LEN = 6,
   parameter int CHAR_ID_LEN = 8,
   parameter int BLANK_ID    = 128,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                clock,
   input  logic                reset,
   text_screen_buffer_if.slave bus
);
   localparam int CELLS      = ROW_NUMBER * COL_NUMBER;
   localparam int COPY_CELLS = (ROW_NUMBER - 1) * COL_NUMBER;
   localparam int ADDR_W     = $clog2(CELLS);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   localparam logic [ADDR_W-1:0]      COL_A        = ADDR_W'(COL_NUMBER);
   localparam logic [ADDR_W-1:0]      COPY_CELLS_A = ADDR_W'(COPY_CELLS);
   localparam logic [ADDR_W-1:0]      LAST_CELL_A  = ADDR_W'(CELLS - 1);
   localparam logic [ROW_BIT_LEN-1:0] ROW_LIM      = ROW_BIT_LEN'(ROW_NUMBER);
   localparam logic [ROW_BIT_LEN-1:0] LAST_ROW     = ROW_BIT_LEN'(ROW_NUMBER - 1);
   localparam logic [COL_BIT_LEN-1:0] COL_LIM      = COL_BIT_LEN'(COL_NUMBER);
   localparam logic [CHAR_ID_LEN-1:0] BLANK        = CHAR_ID_LEN'(BLANK_ID);
   localparam logic [CHAR_ID_LEN-1:0] NO_CHAR      = {CHAR_ID_LEN{1'b1}};

   typedef enum logic [1:0] {CMD_WRITE, CMD_SCROLL, CMD_CLEAR} cmd_kind_t;
   typedef enum logic [1:0] {S_IDLE, S_SCROLL_COPY, S_SCROLL_FILL, S_CLEAR} state_t;

   typedef struct packed {
      cmd_kind_t              kind;
      logic [CHAR_ID_LEN-1:0] ch;
      logic [ROW_BIT_LEN-1:0] row;
      logic [COL_BIT_LEN-1:0] col;
   } cmd_t;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_BIT_LEN-1:0] row,
                                                   input logic [COL_BIT_LEN-1:0] col);
      return ADDR_W'(row) * COL_A + ADDR_W'(col);
   endfunction

   // ---------------- command FIFO ----------------
   cmd_t             r_fifo [FIFO_DEPTH];
   logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
   cmd_t             w_enq_cmd, w_head;
   logic             w_enq_req, w_full, w_empty, w_pop, w_push, w_drop;
   state_t           r_state, w_state_next;

   always_comb begin
      w_enq_cmd.kind = CMD_WRITE;
      w_enq_cmd.ch   = bus.char_id;
      w_enq_cmd.row  = bus.wr_row;
      w_enq_cmd.col  = bus.wr_col;
      w_enq_req      = 1'b0;
      if (bus.wr_valid) begin
         if (bus.reset_call) begin
            w_enq_cmd.kind = CMD_CLEAR;
            w_enq_req      = 1'b1;
         end else if (bus.push_up) begin
            w_enq_cmd.kind = CMD_SCROLL;
            w_enq_cmd.row  = LAST_ROW;
            w_enq_req      = 1'b1;
         end else if (bus.wr_row < ROW_LIM && bus.wr_col < COL_LIM && bus.char_id != NO_CHAR) begin
            w_enq_req      = 1'b1;
         end
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   // a pop in the same cycle frees the slot the incoming entry needs
   assign w_push  = w_enq_req && (!w_full || w_pop);
   assign w_drop  = w_enq_req && w_full && !w_pop;
   assign w_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clock) begin
      if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_enq_cmd;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // ---------------- engine ----------------
   logic [CHAR_ID_LEN-1:0] r_mem [CELLS];
   logic [ADDR_W-1:0]      r_cnt, w_cnt_next;
   logic [CHAR_ID_LEN-1:0] r_fill_char, w_fill_char_next;
   logic [COL_BIT_LEN-1:0] r_fill_col, w_fill_col_next;
   logic                   r_we, w_we_next;
   logic [ADDR_W-1:0]      r_waddr, w_waddr_next;
   logic [CHAR_ID_LEN-1:0] r_wdata, w_wdata_next;
   logic [ADDR_W-1:0]      w_eng_raddr;
   logic [CHAR_ID_LEN-1:0] r_eng_rd;
   logic                   w_ovf_clear;
   logic                   r_overflow;
   logic [CHAR_ID_LEN-1:0] r_rd_char;
   logic                   w_rd_in_range;
   logic [ADDR_W-1:0]      w_rd_addr;

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_fill_char_next = r_fill_char;
      w_fill_col_next  = r_fill_col;
      w_we_next        = 1'b0;
      w_waddr_next     = r_waddr;
      w_wdata_next     = r_wdata;
      w_eng_raddr      = '0;
      w_ovf_clear      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_fill_char_next = w_head.ch;
               w_fill_col_next  = w_head.col;
               w_cnt_next       = '0;
               case (w_head.kind)
                  CMD_SCROLL: w_state_next = S_SCROLL_COPY;
                  CMD_CLEAR:  w_state_next = S_CLEAR;
                  default: begin
                     w_we_next    = 1'b1;
                     w_waddr_next = cell_addr(w_head.row, w_head.col);
                     w_wdata_next = w_head.ch;
                  end
               endcase
            end
         end
         S_SCROLL_COPY: begin
            // read runs one cell ahead of the write: r_eng_rd holds cell (r_cnt-1)+COL
            if (r_cnt != COPY_CELLS_A) w_eng_raddr = r_cnt + COL_A;
            if (r_cnt != '0) begin
               w_we_next    = 1'b1;
               w_waddr_next = r_cnt - 1'b1;
               w_wdata_next = r_eng_rd;
            end
            if (r_cnt == COPY_CELLS_A) begin
               w_state_next = S_SCROLL_FILL;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + 1'b1;
            end
         end
         S_SCROLL_FILL: begin
            if (r_cnt != COL_A) begin
               w_we_next    = 1'b1;
               w_waddr_next = COPY_CELLS_A + r_cnt;
               w_wdata_next = BLANK;
               w_cnt_next   = r_cnt + 1'b1;
            end else begin
               w_state_next = S_IDLE;
               if (r_fill_col < COL_LIM && r_fill_char != NO_CHAR) begin
                  w_we_next    = 1'b1;
                  w_waddr_next = COPY_CELLS_A + ADDR_W'(r_fill_col);
                  w_wdata_next = r_fill_char;
               end
            end
         end
         S_CLEAR: begin
            w_we_next    = 1'b1;
            w_waddr_next = r_cnt;
            w_wdata_next = BLANK;
            if (r_cnt == LAST_CELL_A) begin
               w_state_next = S_IDLE;
               w_ovf_clear  = 1'b1;
            end else begin
               w_cnt_next   = r_cnt + 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
         r_state     <= S_CLEAR;
`else
         r_state     <= S_IDLE;
`endif
         r_cnt       <= '0;
         r_fill_char <= '0;
         r_fill_col  <= '0;
         r_we        <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_fill_char <= w_fill_char_next;
         r_fill_col  <= w_fill_col_next;
         r_we        <= w_we_next;
         r_waddr     <= w_waddr_next;
         r_wdata     <= w_wdata_next;
         if (w_drop)           r_overflow <= 1'b1;
         else if (w_ovf_clear) r_overflow <= 1'b0;
      end
   end

   // ---------------- storage and read ports ----------------
   always_ff @(posedge clock) begin
      if (r_we) r_mem[r_waddr] <= r_wdata;
      r_eng_rd <= r_mem[w_eng_raddr];
   end

   assign w_rd_in_range = (bus.rd_row < ROW_LIM) && (bus.rd_col < COL_LIM);
   assign w_rd_addr     = cell_addr(bus.rd_row, bus.rd_col);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)              r_rd_char <= BLANK;
      else if (w_rd_in_range) r_rd_char <= r_mem[w_rd_addr];
      else                    r_rd_char <= BLANK;
   end

   assign bus.rd_char  = r_rd_char;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_text_screen_buffer.sv
// Scoreboard bench for text_screen_buffer: reads push expectations, a negedge monitor checks rd_char.
module tb_text_screen_buffer;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   text_screen_buffer_if bus ();

   text_screen_buffer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int exp;
      int row;
      int col;
   } rd_exp_t;

   int      n_checks = 0;
   int      n_fail   = 0;
   rd_exp_t sb_q[$];
   logic    rd_req   = 1'b0;
   logic    rd_req_d = 1'b0;
   int      model [15][40];

   always @(posedge clock) rd_req_d <= rd_req;

   always @(negedge clock) begin : monitor
      rd_exp_t e;
      if (rd_req_d) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_char: got %0d with no expected entry queued", bus.rd_char);
         end else begin
            e = sb_q.pop_front();
            if (int'(bus.rd_char) != e.exp) begin
               n_fail++;
               $display("FAIL rd_char(%0d,%0d): got %0d expected %0d", e.row, e.col, bus.rd_char, e.exp);
            end else begin
               $display("read (%0d,%0d) = %0d ok", e.row, e.col, bus.rd_char);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end else begin
         $display("check %s = %0d ok", name, got);
      end
   endtask

   task automatic feed(input int r, input int c, input int ch, input bit pu, input bit rc);
      bus.wr_valid   = 1'b1;
      bus.wr_row     = 4'(r);
      bus.wr_col     = 6'(c);
      bus.char_id    = 8'(ch);
      bus.push_up    = pu;
      bus.reset_call = rc;
      tick();
      bus.wr_valid   = 1'b0;
      bus.push_up    = 1'b0;
      bus.reset_call = 1'b0;
   endtask

   task automatic rd_cell(input int r, input int c, input int e);
      bus.rd_row = 4'(r);
      bus.rd_col = 6'(c);
      rd_req     = 1'b1;
      sb_q.push_back('{e, r, c});
      tick();
      rd_req     = 1'b0;
   endtask

   task automatic measure_busy(output int cnt);
      bit seen = 1'b0;
      cnt = 0;
      for (int g = 0; g < 2000; g++) begin
         tick();
         if (bus.busy) begin
            cnt++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
      end
   endtask

   task automatic m_write(input int r, input int c, input int ch);
      if (r < 15 && c < 40 && ch != 255) model[r][c] = ch;
   endtask

   task automatic m_scroll(input int c, input int ch);
      for (int r = 0; r < 14; r++)
         for (int k = 0; k < 40; k++) model[r][k] = model[r+1][k];
      for (int k = 0; k < 40; k++) model[14][k] = 128;
      if (c < 40 && ch != 255) model[14][c] = ch;
   endtask

   task automatic m_clear();
      for (int r = 0; r < 15; r++)
         for (int k = 0; k < 40; k++) model[r][k] = 128;
   endtask

   initial begin
      int cnt;
      reset          = 1'b1;
      bus.wr_valid   = 1'b0;
      bus.char_id    = '0;
      bus.wr_row     = '0;
      bus.wr_col     = '0;
      bus.push_up    = 1'b0;
      bus.reset_call = 1'b0;
      bus.rd_row     = '0;
      bus.rd_col     = '0;
      for (int r = 0; r < 15; r++)
         for (int k = 0; k < 40; k++) model[r][k] = -1;
      tick();
      tick();
      check("reset rd_char", int'(bus.rd_char), 128);
      check("reset overflow", int'(bus.overflow), 0);
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
      check("reset busy", int'(bus.busy), 1);
      reset = 1'b0;
      measure_busy(cnt);
      check("power-on clear busy cycles after release", cnt, 599);
      m_clear();
      tick();
      rd_cell(0, 0, 128);
      rd_cell(7, 20, 128);
      rd_cell(14, 39, 128);
`else
      check("reset busy", int'(bus.busy), 0);
      reset = 1'b0;
      tick();
`endif

      // single WRITE, no busy
      feed(2, 5, 36, 1'b0, 1'b0);
      m_write(2, 5, 36);
      tick();
      check("write busy N+1", int'(bus.busy), 0);
      tick();
      check("write busy N+2", int'(bus.busy), 0);
      rd_cell(2, 5, model[2][5]);

      // CLEAR
      feed(0, 0, 0, 1'b0, 1'b1);
      measure_busy(cnt);
      check("clear busy cycles", cnt, 600);
      m_clear();
      tick();
      check("overflow after clear", int'(bus.overflow), 0);
      rd_cell(0, 0, 128);
      rd_cell(14, 39, 128);
      rd_cell(2, 5, 128);

      // fill whole screen, then scroll with char 7 at col 0 (row field must be ignored)
      for (int r = 0; r < 15; r++)
         for (int k = 0; k < 40; k++) begin
            feed(r, k, (r * 40 + k) % 251, 1'b0, 1'b0);
            m_write(r, k, (r * 40 + k) % 251);
         end
      tick();
      tick();
      tick();
      rd_cell(1, 17, model[1][17]);
      rd_cell(14, 39, model[14][39]);
      feed(3, 0, 7, 1'b1, 1'b0);
      m_scroll(0, 7);
      measure_busy(cnt);
      check("scroll busy cycles", cnt, 602);
      check("busy low after scroll", int'(bus.busy), 0);
      tick();
      foreach (model[r]) begin
         if (r == 0 || r == 7 || r == 13 || r == 14)
            for (int k = 0; k < 40; k++) rd_cell(r, k, model[r][k]);
      end

      // scroll followed by 5 WRITEs: 4 queue, the 5th overflows
      feed(0, 39, 9, 1'b1, 1'b0);
      m_scroll(39, 9);
      feed(0, 0, 11, 1'b0, 1'b0);
      feed(0, 1, 12, 1'b0, 1'b0);
      feed(5, 5, 13, 1'b0, 1'b0);
      feed(0, 0, 14, 1'b0, 1'b0);
      feed(1, 1, 15, 1'b0, 1'b0);
      check("overflow set on full FIFO", int'(bus.overflow), 1);
      m_write(0, 0, 11);
      m_write(0, 1, 12);
      m_write(5, 5, 13);
      m_write(0, 0, 14);
      measure_busy(cnt);
      check("remaining scroll busy cycles", cnt, 597);
      for (int i = 0; i < 6; i++) tick();
      check("overflow sticky", int'(bus.overflow), 1);
      rd_cell(0, 0, model[0][0]);
      rd_cell(0, 1, model[0][1]);
      rd_cell(5, 5, model[5][5]);
      rd_cell(1, 1, model[1][1]);
      rd_cell(14, 38, model[14][38]);
      rd_cell(14, 39, model[14][39]);
      rd_cell(13, 0, model[13][0]);

      // rejected writes leave storage unchanged
      feed(15, 3, 50, 1'b0, 1'b0);
      feed(3, 3, 255, 1'b0, 1'b0);
      feed(0, 40, 51, 1'b0, 1'b0);
      tick();
      check("no busy on rejected writes", int'(bus.busy), 0);
      tick();
      tick();
      rd_cell(3, 3, model[3][3]);
      rd_cell(14, 3, model[14][3]);
      rd_cell(0, 39, model[0][39]);
      rd_cell(15, 3, 128);
      rd_cell(4, 45, 128);

      // CLEAR drops sticky overflow
      feed(0, 0, 0, 1'b0, 1'b1);
      m_clear();
      measure_busy(cnt);
      check("second clear busy cycles", cnt, 600);
      check("overflow cleared by CLEAR", int'(bus.overflow), 0);
      tick();
      rd_cell(0, 0, 128);
      rd_cell(5, 5, 128);

      // asynchronous reset mid-clear
      feed(0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      check("busy mid clear", int'(bus.busy), 1);
      #2;
      reset = 1'b1;
      #1;
`ifdef TEXT_BUFFER_CLEAR_ON_RESET_EN
      check("busy in reset", int'(bus.busy), 1);
`else
      check("busy in reset", int'(bus.busy), 0);
`endif
      check("rd_char in reset", int'(bus.rd_char), 128);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("scoreboard drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
